// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the 4-bit multi-mode counter, its
// checker and bench models.
//   - mode encodings (must match the counter)
//   - checker FSM state encoding
//   - bit positions inside the checker's err_vec output
package counter_pkg;

    // Counter mode encodings
    localparam logic [1:0] Q_P_ONE   = 2'b00;  // count up by 1
    localparam logic [1:0] Q_M_ONE   = 2'b01;  // count down by 1
    localparam logic [1:0] Q_M_THREE = 2'b10;  // count down by 3
    localparam logic [1:0] Q_D       = 2'b11;  // parallel load of D

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_CHECK = 2'b10,
        ST_HALT  = 2'b11
    } chk_state_t;

    // err_vec bit indices: err_vec = {load, rco, Q}
    localparam int ERR_Q    = 0;
    localparam int ERR_RCO  = 1;
    localparam int ERR_LOAD = 2;

endpackage

// File: rtl/counter_predictor.sv
// counter_predictor: purely combinational next-state model of the 4-bit
// multi-mode counter. Given the counter's stimulus and its present outputs
// it returns the outputs the counter must register on the next edge.
//
// Ports:
//   enable  in  1  counter enable
//   mode    in  2  counter mode (counter_pkg encodings)
//   D       in  4  load data
//   Q       in  4  present counter value
//   rco     in  1  present ripple-carry
//   Q_n     out 4  predicted next Q
//   rco_n   out 1  predicted next rco
//   load_n  out 1  predicted next load flag
module counter_predictor
    import counter_pkg::*;
(
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [3:0] D,
    input  logic [3:0] Q,
    input  logic       rco,
    output logic [3:0] Q_n,
    output logic       rco_n,
    output logic       load_n
);

    always_comb begin
        Q_n    = 4'd0;
        rco_n  = rco;
        load_n = 1'b0;
        if (!enable) begin
            // Disabled counter clears Q; rco holds unless a load is requested.
            if (mode == Q_D) begin
                rco_n  = 1'b0;
                load_n = 1'b1;
            end
        end else begin
            // rco always reflects the pre-update Q; arithmetic wraps mod 16.
            case (mode)
                Q_P_ONE: begin
                    Q_n   = Q + 4'd1;
                    rco_n = (Q == 4'd15);
                end
                Q_M_ONE: begin
                    Q_n   = Q - 4'd1;
                    rco_n = (Q == 4'd0);
                end
                Q_M_THREE: begin
                    Q_n   = Q - 4'd3;
                    rco_n = (Q <= 4'd2);
                end
                default: begin
                    Q_n    = D;
                    rco_n  = 1'b0;
                    load_n = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_checker.sv
// counter_checker: monitor/scoreboard for the 4-bit multi-mode counter.
// Predicts the counter's registered outputs one cycle ahead from its present
// outputs and stimulus, compares each cycle and reports mismatches.
//
// Ports:
//   clk      in  1      clock, posedge
//   reset    in  1      synchronous, active-high
//   chk_en   in  1      checking enable
//   enable   in  1      tapped counter enable
//   mode     in  2      tapped counter mode
//   D        in  4      tapped counter load data
//   Q        in  4      tapped counter output
//   rco      in  1      tapped ripple-carry
//   load     in  1      tapped load flag
//   err      out 1      one-cycle mismatch pulse
//   err_vec  out 3      mismatch bits {load, rco, Q} while err=1, else 0
//   err_cnt  out ERR_W  mismatching cycles, saturating
//   chk_cnt  out CNT_W  compared cycles, saturating
//   halted   out 1      high while in HALT
//   state    (internal) FSM state, visible for checkers to bind to
module counter_checker
    import counter_pkg::*;
#(
    parameter int ERR_LIMIT = 4,
    parameter int ERR_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3:0]       D,
    input  logic [3:0]       Q,
    input  logic             rco,
    input  logic             load,
    output logic             err,
    output logic [2:0]       err_vec,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic             halted
);

    // A limit beyond the saturating range of err_cnt can never be reached.
    localparam bit               LIMIT_ON = (ERR_LIMIT != 0) && (ERR_LIMIT < (1 << ERR_W));
    localparam logic [ERR_W-1:0] LIMIT_V  = ERR_W'(ERR_LIMIT);

    chk_state_t state;

    logic [3:0] pred_q;
    logic       pred_rco;
    logic       pred_load;

    logic [3:0] p_q;
    logic       p_rco;
    logic       p_load;

    logic [2:0]       mm;
    logic [ERR_W-1:0] err_cnt_inc;
    logic [CNT_W-1:0] chk_cnt_inc;
    logic             limit_hit;

    // Prediction always comes from the counter's present outputs, so one
    // wrong value does not cascade into later mismatches.
    counter_predictor u_pred (
        .enable (enable),
        .mode   (mode),
        .D      (D),
        .Q      (Q),
        .rco    (rco),
        .Q_n    (p_q),
        .rco_n  (p_rco),
        .load_n (p_load)
    );

    always_comb begin
        mm            = 3'b000;
        mm[ERR_Q]     = (pred_q    != Q);
        mm[ERR_RCO]   = (pred_rco  != rco);
        mm[ERR_LOAD]  = (pred_load != load);
        err_cnt_inc   = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);
        chk_cnt_inc   = (chk_cnt == {CNT_W{1'b1}}) ? chk_cnt : chk_cnt + CNT_W'(1);
        limit_hit     = LIMIT_ON && (err_cnt_inc == LIMIT_V);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            err       <= 1'b0;
            err_vec   <= 3'b000;
            err_cnt   <= '0;
            chk_cnt   <= '0;
            halted    <= 1'b0;
            pred_q    <= 4'd0;
            pred_rco  <= 1'b0;
            pred_load <= 1'b0;
        end else begin
            // err/err_vec are pulses: cleared unless a mismatch is found.
            err     <= 1'b0;
            err_vec <= 3'b000;
            if (!chk_en) begin
                // Dropping chk_en always wins, including over a limit hit.
                // Counters are deliberately kept.
                state  <= ST_IDLE;
                halted <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_PRIME;
                    end
                    ST_PRIME: begin
                        pred_q    <= p_q;
                        pred_rco  <= p_rco;
                        pred_load <= p_load;
                        state     <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        pred_q    <= p_q;
                        pred_rco  <= p_rco;
                        pred_load <= p_load;
                        chk_cnt   <= chk_cnt_inc;
                        if (|mm) begin
                            err     <= 1'b1;
                            err_vec <= mm;
                            err_cnt <= err_cnt_inc;
                            if (limit_hit) begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                        end
                    end
                    ST_HALT: begin
                        halted <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed bench for counter_checker. The bench plays
// the monitored counter by driving Q/rco/load directly. Two checkers run
// side by side on the same stimulus: dut_a with default parameters and
// dut_b with ERR_W=2, ERR_LIMIT=0 for the saturation case.
module tb_counter_checker;
    import counter_pkg::*;

    logic       clk;
    logic       reset;
    logic       chk_en;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] D;
    logic [3:0] Q;
    logic       rco;
    logic       load;

    logic        err_a;
    logic [2:0]  err_vec_a;
    logic [7:0]  err_cnt_a;
    logic [15:0] chk_cnt_a;
    logic        halted_a;

    logic        err_b;
    logic [2:0]  err_vec_b;
    logic [1:0]  err_cnt_b;
    logic [15:0] chk_cnt_b;
    logic        halted_b;

    int checks;
    int errors;

    logic [3:0] qv;
    logic       rv;

    counter_checker dut_a (
        .clk     (clk),
        .reset   (reset),
        .chk_en  (chk_en),
        .enable  (enable),
        .mode    (mode),
        .D       (D),
        .Q       (Q),
        .rco     (rco),
        .load    (load),
        .err     (err_a),
        .err_vec (err_vec_a),
        .err_cnt (err_cnt_a),
        .chk_cnt (chk_cnt_a),
        .halted  (halted_a)
    );

    counter_checker #(.ERR_LIMIT(0), .ERR_W(2), .CNT_W(16)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .chk_en  (chk_en),
        .enable  (enable),
        .mode    (mode),
        .D       (D),
        .Q       (Q),
        .rco     (rco),
        .load    (load),
        .err     (err_b),
        .err_vec (err_vec_b),
        .err_cnt (err_cnt_b),
        .chk_cnt (chk_cnt_b),
        .halted  (halted_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single checking task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Driver: present one cycle of counter stimulus/outputs, then take the
    // edge and settle 1 time unit past it before any sampling.
    task automatic drive(input logic en, input logic [1:0] md, input logic [3:0] d,
                         input logic [3:0] q, input logic r, input logic l);
        enable = en;
        mode   = md;
        D      = d;
        Q      = q;
        rco    = r;
        load   = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        chk_en = 1'b0;

        // Reset
        drive(1'b0, Q_P_ONE, 4'h0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, Q_P_ONE, 4'h0, 4'h0, 1'b0, 1'b0);
        check("rst_err",     err_a,     0);
        check("rst_err_vec", err_vec_a, 0);
        check("rst_err_cnt", err_cnt_a, 0);
        check("rst_chk_cnt", chk_cnt_a, 0);
        check("rst_halted",  halted_a,  0);
        check("rst_b_cnt",   err_cnt_b, 0);
        reset = 1'b0;

        // Correct up counter: IDLE->PRIME edge, then 20 edges (PRIME + 19 compares)
        chk_en = 1'b1;
        drive(1'b1, Q_P_ONE, 4'h0, 4'h0, 1'b0, 1'b0);
        check("idle_no_err", err_a, 0);
        for (int i = 0; i < 20; i++) begin
            qv = 4'(i);
            rv = (i > 0) && (qv == 4'd0);
            drive(1'b1, Q_P_ONE, 4'h0, qv, rv, 1'b0);
            check("up_err", err_a, 0);
        end
        check("up_chk_cnt", chk_cnt_a, 19);
        check("up_err_cnt", err_cnt_a, 0);

        // Down by 3: 4 -> 1 -> (predicted 14, rco=1), DUT forced to 13
        drive(1'b1, Q_M_THREE, 4'h0, 4'd4, 1'b0, 1'b0);
        check("dn3_a", err_a, 0);
        drive(1'b1, Q_M_THREE, 4'h0, 4'd1, 1'b0, 1'b0);
        check("dn3_b", err_a, 0);
        drive(1'b1, Q_M_THREE, 4'h0, 4'd13, 1'b1, 1'b0);
        check("dn3_wrap_err",     err_a,     1);
        check("dn3_wrap_err_vec", err_vec_a, 3'b001);
        check("dn3_wrap_err_cnt", err_cnt_a, 1);

        // 13-3=10 accepted, err pulse drops; stimulus now enable=0, mode=Q_D
        drive(1'b0, Q_D, 4'h0, 4'd10, 1'b0, 1'b0);
        check("pulse_drop", err_a,     0);
        check("pulse_vec0", err_vec_a, 0);
        // Load flag should be 1; forced 0
        drive(1'b0, Q_P_ONE, 4'h0, 4'd0, 1'b0, 1'b0);
        check("dis_load_err", err_a,     1);
        check("dis_load_vec", err_vec_a, 3'b100);
        check("dis_load_cnt", err_cnt_a, 2);

        // Down by 1 from 0 gives 15, rco=1; then enable=0 in up mode holds rco
        drive(1'b1, Q_M_ONE, 4'h0, 4'd0, 1'b0, 1'b0);
        check("dn1_ok", err_a, 0);
        drive(1'b0, Q_P_ONE, 4'h0, 4'd15, 1'b1, 1'b0);
        check("dn1_wrap", err_a, 0);
        drive(1'b0, Q_P_ONE, 4'h0, 4'd0, 1'b1, 1'b0);
        check("hold_rco_a", err_a, 0);
        drive(1'b0, Q_P_ONE, 4'h0, 4'd0, 1'b1, 1'b0);
        check("hold_rco_b", err_a, 0);

        // Load D=A, then count from A
        drive(1'b1, Q_D, 4'hA, 4'd0, 1'b1, 1'b0);
        check("load_req", err_a, 0);
        drive(1'b1, Q_P_ONE, 4'h0, 4'hA, 1'b0, 1'b1);
        check("load_seen", err_a, 0);
        check("pre_rst_chk_cnt", chk_cnt_a, 30);
        check("pre_rst_err_cnt", err_cnt_a, 2);

        // Reset mid-CHECK with a value that would otherwise mismatch
        reset = 1'b1;
        drive(1'b1, Q_P_ONE, 4'h0, 4'd5, 1'b0, 1'b0);
        check("mid_rst_err",     err_a,     0);
        check("mid_rst_err_vec", err_vec_a, 0);
        check("mid_rst_err_cnt", err_cnt_a, 0);
        check("mid_rst_chk_cnt", chk_cnt_a, 0);
        check("mid_rst_halted",  halted_a,  0);
        reset = 1'b0;

        // Re-enable: IDLE->PRIME edge, PRIME edge (garbage ignored), then compares
        drive(1'b1, Q_P_ONE, 4'h0, 4'd7, 1'b0, 1'b1);
        check("re_idle", err_a, 0);
        drive(1'b1, Q_P_ONE, 4'h0, 4'd3, 1'b1, 1'b1);
        check("re_prime",     err_a,     0);
        check("re_prime_cnt", chk_cnt_a, 0);
        drive(1'b1, Q_P_ONE, 4'h0, 4'd4, 1'b0, 1'b0);
        check("re_check",     err_a,     0);
        check("re_check_cnt", chk_cnt_a, 1);

        // Mismatch every cycle: Q stuck at 0 while counting up
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, Q_P_ONE, 4'h0, 4'd0, 1'b0, 1'b0);
            check("inj_err",     err_a,     1);
            check("inj_err_vec", err_vec_a, 3'b001);
            check("inj_err_cnt", err_cnt_a, i);
            check("inj_halted",  halted_a,  (i == 4));
            check("inj_b_err",   err_b,     1);
            check("inj_b_cnt",   err_cnt_b, (i > 3) ? 3 : i);
        end
        // Fifth mismatch: dut_a halted, dut_b saturated but still checking
        drive(1'b1, Q_P_ONE, 4'h0, 4'd0, 1'b0, 1'b0);
        check("halt_no_err",  err_a,     0);
        check("halt_err_cnt", err_cnt_a, 4);
        check("halt_chk_cnt", chk_cnt_a, 5);
        check("halt_halted",  halted_a,  1);
        check("sat_b_err",    err_b,     1);
        check("sat_b_cnt",    err_cnt_b, 3);
        check("sat_b_halted", halted_b,  0);

        // Drop chk_en: back to IDLE, counters kept
        chk_en = 1'b0;
        drive(1'b1, Q_P_ONE, 4'h0, 4'd0, 1'b0, 1'b0);
        check("exit_halted",  halted_a,  0);
        check("exit_err",     err_a,     0);
        check("exit_err_cnt", err_cnt_a, 4);
        check("exit_b_err",   err_b,     0);
        check("exit_b_cnt",   err_cnt_b, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
